kernel_window_loader: RTL and testbench
=======================================

KERNEL_WINDOW_LOADER -- requirements
Module: kernel_window_loader

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, giving the byte-address width of the pixel memory.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request a full 3x3 window load.
REQ-005 The block SHALL have port shift, input, 1 bit: request a one-column slide of the current window to the right.
REQ-006 The block SHALL have port base_addr, input, ADDR_W bits: top-left pixel address, sampled with start.
REQ-007 The block SHALL have port stride, input, ADDR_W bits: row pitch in bytes, sampled with start.
REQ-008 The block SHALL have port mem_rdata, input, 8 bits: read data, valid the cycle after a read is issued.
REQ-009 The block SHALL have port mem_addr, output, ADDR_W bits: registered read address.
REQ-010 The block SHALL have port mem_ren, output, 1 bit: registered read enable.
REQ-011 The block SHALL have port cache, output, array [0:2] of 24 bits: window rows feeding the ALU kernel unit.
REQ-012 The block SHALL have port busy, output, 1 bit: high from the edge accepting a request until the commit edge.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle pulse; cache is updated.

Function
REQ-014 The block SHALL lay out each row as cache[r][23:16]=col0, [15:8]=col1, [7:0]=col2.
REQ-015 The block SHALL compute each read address as base + r*stride + c, modulo 2^ADDR_W; wrap-around is silent.
REQ-016 The block SHALL have FSM states IDLE, FETCH and DRAIN.
- IDLE -> FETCH on an accepted request.
- FETCH issues one read per cycle, row-major.
- FETCH -> DRAIN after the last issue.
- DRAIN captures the final byte, commits, and returns to IDLE.
REQ-017 A start sampled in IDLE at edge E0 SHALL:
- latch base_addr and stride;
- issue 9 reads in the cycles after E0 through E8;
- commit at E10, with done high for the cycle following E10.
REQ-018 A shift sampled in IDLE at edge E0 SHALL:
- increment the base register by 1;
- issue 3 reads at new_base + r*stride + 2 for r=0..2;
- commit cache[r] = {old cache[r][15:0], byte r} at E4, with done high for the following cycle.
REQ-019 The block SHALL collect fetched bytes in a shadow buffer; cache SHALL change only at the commit edge, so the kernel never sees a partial window.
REQ-020 start and shift asserted together in IDLE SHALL be treated as start.
REQ-021 start or shift while busy=1 SHALL be ignored, with no queuing.
REQ-022 shift with no prior start SHALL be accepted, using the reset base (0) and stride (0).
REQ-023 mem_rdata SHALL be ignored in any cycle not following an issued read.
REQ-024 mem_ren SHALL be 0 in IDLE and on the commit cycle.

Reset
REQ-025 While rst=1 the block SHALL hold:
- FSM=IDLE;
- cache[0..2]=24'h000000;
- base and stride registers = 0;
- mem_addr=0, mem_ren=0, busy=0, done=0.
REQ-026 Reset asserted mid-operation SHALL abort the load, discard shadow data and outstanding read data, and leave cache at zero.

Verification
Memory model: mem[a]=a[7:0], 1-cycle read latency.
REQ-027 Full load, base_addr=16'h0100, stride=16'h0010 -> cache = {24'h000102, 24'h101112, 24'h202122}; done one cycle at edge 10; exactly 9 mem_ren cycles.
REQ-028 shift after REQ-027 -> reads 16'h0103, 16'h0113, 16'h0123; cache = {24'h010203, 24'h111213, 24'h212223}; done at edge 4.
REQ-029 Wrap, base_addr=16'hFFFF, stride=16'h0001 -> cache[0]=24'hFF0001, cache[1]=24'h000102, cache[2]=24'h010203.
REQ-030 rst pulsed 5 cycles into a load -> mem_ren=0, busy=0, done=0, cache all zero; a following start with REQ-027 values yields REQ-027 results.
REQ-031 start+shift together -> full 9-read load; start re-asserted every cycle while busy -> still exactly 9 reads and a single done pulse.

Source files
------------

// File: rtl/kernel_window_loader_if.sv
// Bundle of request, memory-read and window-output signals for kernel_window_loader.
// The master side drives requests and memory read data; the slave is the loader.
interface kernel_window_loader_if #(
    parameter int ADDR_W = 16
);
    logic              start;
    logic              shift;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] stride;
    logic [7:0]        mem_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ren;
    logic [23:0]       cache [0:2];
    logic              busy;
    logic              done;

    modport master (
        output start, shift, base_addr, stride, mem_rdata,
        input  mem_addr, mem_ren, cache, busy, done
    );

    modport slave (
        input  start, shift, base_addr, stride, mem_rdata,
        output mem_addr, mem_ren, cache, busy, done
    );
endinterface

// File: rtl/kernel_window_loader.sv
// Loads a 3x3 pixel window (or slides it one column right) from a byte memory
// with one-cycle read latency; the window is committed atomically from a shadow buffer.
module kernel_window_loader #(
    parameter int ADDR_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    kernel_window_loader_if.slave bus
);
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t            state_r, state_nxt_s;
    logic [ADDR_W-1:0] base_r, stride_r, off_r;
    logic [1:0]        row_r, col_r;
    logic              mode_shift_r;
    logic [3:0]        iss_slot_r, pend_slot_r;
    logic              pend_r;
    logic [7:0]        shadow_r     [0:8];
    logic [7:0]        shadow_nxt_s [0:8];

    logic              accept_s, issue_s, last_issue_s, commit_s, cur_shift_s;
    logic [ADDR_W-1:0] cur_base_s, cur_stride_s, cur_off_s, issue_addr_s;
    logic [1:0]        cur_row_s, cur_col_s;
    logic [3:0]        issue_slot_s;

    // Issue-side view: on the accepting edge the first read uses the freshly selected base/stride.
    always_comb begin
        accept_s = (state_r == IDLE) && (bus.start || bus.shift);
        if (accept_s) begin
            cur_shift_s  = !bus.start;
            cur_stride_s = bus.start ? bus.stride : stride_r;
            cur_base_s   = bus.start ? bus.base_addr : (base_r + {{(ADDR_W-1){1'b0}}, 1'b1});
            cur_row_s    = 2'd0;
            cur_col_s    = bus.start ? 2'd0 : 2'd2;
            cur_off_s    = {ADDR_W{1'b0}};
        end else begin
            cur_shift_s  = mode_shift_r;
            cur_stride_s = stride_r;
            cur_base_s   = base_r;
            cur_row_s    = row_r;
            cur_col_s    = col_r;
            cur_off_s    = off_r;
        end
        issue_s      = accept_s || (state_r == FETCH);
        issue_addr_s = cur_base_s + cur_off_s + {{(ADDR_W-2){1'b0}}, cur_col_s};
        issue_slot_s = ({2'b00, cur_row_s} * 4'd3) + {2'b00, cur_col_s};
        last_issue_s = issue_s && (cur_row_s == 2'd2) && (cur_col_s == 2'd2);
    end

    // Shadow capture (including the byte arriving on the commit edge) and FSM next state.
    always_comb begin
        shadow_nxt_s = shadow_r;
        if (pend_r) begin
            shadow_nxt_s[pend_slot_r] = bus.mem_rdata;
        end else begin
            shadow_nxt_s = shadow_r;
        end
        commit_s    = (state_r == DRAIN) && pend_r && (pend_slot_r == 4'd8);
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_nxt_s = FETCH;
                else          state_nxt_s = IDLE;
            end
            FETCH: begin
                if (last_issue_s) state_nxt_s = DRAIN;
                else              state_nxt_s = FETCH;
            end
            DRAIN: begin
                if (commit_s) state_nxt_s = IDLE;
                else          state_nxt_s = DRAIN;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= IDLE;
        else     state_r <= state_nxt_s;
    end

    // Read issue, read-return tracking, window geometry and registered status.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.mem_ren  <= 1'b0;
            bus.mem_addr <= {ADDR_W{1'b0}};
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            iss_slot_r   <= 4'd0;
            pend_r       <= 1'b0;
            pend_slot_r  <= 4'd0;
            base_r       <= {ADDR_W{1'b0}};
            stride_r     <= {ADDR_W{1'b0}};
            off_r        <= {ADDR_W{1'b0}};
            row_r        <= 2'd0;
            col_r        <= 2'd0;
            mode_shift_r <= 1'b0;
        end else begin
            bus.mem_ren <= issue_s;
            iss_slot_r  <= issue_slot_s;
            pend_r      <= bus.mem_ren;
            pend_slot_r <= iss_slot_r;
            bus.done    <= commit_s;
            if (issue_s) bus.mem_addr <= issue_addr_s;
            else         bus.mem_addr <= bus.mem_addr;
            if (accept_s)      bus.busy <= 1'b1;
            else if (commit_s) bus.busy <= 1'b0;
            else               bus.busy <= bus.busy;
            if (accept_s) begin
                base_r       <= cur_base_s;
                stride_r     <= cur_stride_s;
                mode_shift_r <= cur_shift_s;
            end
            // A slide stays in column 2, so every issue in that mode advances the row.
            if (issue_s) begin
                if (cur_col_s == 2'd2) begin
                    col_r <= cur_shift_s ? 2'd2 : 2'd0;
                    row_r <= cur_row_s + 2'd1;
                    off_r <= cur_off_s + cur_stride_s;
                end else begin
                    col_r <= cur_col_s + 2'd1;
                    row_r <= cur_row_s;
                    off_r <= cur_off_s;
                end
            end
        end
    end

    // Shadow buffer and the kernel-facing window, updated only on commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 9; i++) shadow_r[i] <= 8'h00;
            for (int r = 0; r < 3; r++) bus.cache[r] <= 24'h000000;
        end else begin
            shadow_r <= shadow_nxt_s;
            if (commit_s) begin
                for (int r = 0; r < 3; r++) begin
                    if (mode_shift_r)
                        bus.cache[r] <= {bus.cache[r][15:0], shadow_nxt_s[r*3+2]};
                    else
                        bus.cache[r] <= {shadow_nxt_s[r*3], shadow_nxt_s[r*3+1], shadow_nxt_s[r*3+2]};
                end
            end
        end
    end
endmodule

// File: tb/tb_kernel_window_loader.sv
// Directed, table-driven bench for kernel_window_loader with a mem[a]=a[7:0] model.
module tb_kernel_window_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    kernel_window_loader_if #(.ADDR_W(16)) bus ();
    kernel_window_loader #(.ADDR_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // One-cycle-latency memory; returns junk when no read was issued.
    always @(posedge clk) begin
        if (bus.mem_ren) bus.mem_rdata <= bus.mem_addr[7:0];
        else             bus.mem_rdata <= 8'($urandom);
    end

    typedef struct {
        logic        st;
        logic        sh;
        logic        hold;
        logic [15:0] base;
        logic [15:0] stride;
        logic [23:0] c0, c1, c2;
        int          reads;
        int          dedge;
        logic [15:0] fa, la;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_op(input logic st, input logic sh, input logic hold,
                          input logic [15:0] b, input logic [15:0] s,
                          output int reads, output int dedge, output int dones,
                          output int busys, output logic [15:0] fa, output logic [15:0] la);
        reads = 0; dedge = -1; dones = 0; busys = 0; fa = 16'h0000; la = 16'h0000;
        @(negedge clk);
        bus.start = st; bus.shift = sh; bus.base_addr = b; bus.stride = s;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (bus.mem_ren) begin
                if (reads == 0) fa = bus.mem_addr;
                la = bus.mem_addr;
                reads++;
            end
            if (bus.busy) busys++;
            if (bus.done) begin
                if (dones == 0) dedge = k;
                dones++;
            end
            bus.shift = 1'b0;
            if (!hold || dones > 0) bus.start = 1'b0;
        end
    endtask

    initial begin
        int reads, dedge, dones, busys;
        logic [15:0] fa, la;

        vecs[0] = '{1'b1, 1'b0, 1'b0, 16'h0100, 16'h0010, 24'h000102, 24'h101112, 24'h202122, 9, 10, 16'h0100, 16'h0122};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 16'h7777, 16'h3333, 24'h010203, 24'h111213, 24'h212223, 3, 4, 16'h0103, 16'h0123};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 16'hFFFF, 16'h0001, 24'hFF0001, 24'h000102, 24'h010203, 9, 10, 16'hFFFF, 16'h0003};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 16'h0100, 16'h0010, 24'h000102, 24'h101112, 24'h202122, 9, 10, 16'h0100, 16'h0122};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 16'h0230, 16'h0005, 24'h303132, 24'h353637, 24'h3A3B3C, 9, 10, 16'h0230, 16'h023C};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 24'h313233, 24'h363738, 24'h3B3C3D, 3, 4, 16'h0233, 16'h023D};

        bus.start = 1'b0; bus.shift = 1'b0; bus.base_addr = 16'h0000; bus.stride = 16'h0000;
        repeat (2) @(negedge clk);
        chk("rst_ren",   {31'd0, bus.mem_ren}, 32'd0);
        chk("rst_busy",  {31'd0, bus.busy}, 32'd0);
        chk("rst_done",  {31'd0, bus.done}, 32'd0);
        chk("rst_addr",  {16'd0, bus.mem_addr}, 32'd0);
        chk("rst_cache", {8'd0, bus.cache[0] | bus.cache[1] | bus.cache[2]}, 32'd0);
        rst = 1'b0;

        // Shift straight out of reset: base 0 -> 1, stride 0, so every row reads address 3.
        run_op(1'b0, 1'b1, 1'b0, 16'h5555, 16'h7777, reads, dedge, dones, busys, fa, la);
        chk("rshift_reads", 32'(reads), 32'd3);
        chk("rshift_addr",  {16'd0, fa}, 32'h0003);
        chk("rshift_c0",    {8'd0, bus.cache[0]}, 32'h000003);
        chk("rshift_c2",    {8'd0, bus.cache[2]}, 32'h000003);
        chk("rshift_edge",  32'(dedge), 32'd4);

        // Reset five cycles into a full load must abort it and leave the window empty.
        @(negedge clk);
        bus.start = 1'b1; bus.base_addr = 16'h0100; bus.stride = 16'h0010;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_ren",   {31'd0, bus.mem_ren}, 32'd0);
        chk("mid_rst_busy",  {31'd0, bus.busy}, 32'd0);
        chk("mid_rst_done",  {31'd0, bus.done}, 32'd0);
        chk("mid_rst_cache", {8'd0, bus.cache[0] | bus.cache[1] | bus.cache[2]}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        reads = 0; dones = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.mem_ren) reads++;
            if (bus.done) dones++;
        end
        chk("post_rst_reads", 32'(reads), 32'd0);
        chk("post_rst_dones", 32'(dones), 32'd0);
        chk("post_rst_cache", {8'd0, bus.cache[0] | bus.cache[1] | bus.cache[2]}, 32'd0);

        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].st, vecs[i].sh, vecs[i].hold, vecs[i].base, vecs[i].stride,
                   reads, dedge, dones, busys, fa, la);
            chk($sformatf("v%0d_c0", i), {8'd0, bus.cache[0]}, {8'd0, vecs[i].c0});
            chk($sformatf("v%0d_c1", i), {8'd0, bus.cache[1]}, {8'd0, vecs[i].c1});
            chk($sformatf("v%0d_c2", i), {8'd0, bus.cache[2]}, {8'd0, vecs[i].c2});
            chk($sformatf("v%0d_reads", i), 32'(reads), 32'(vecs[i].reads));
            chk($sformatf("v%0d_done_edge", i), 32'(dedge), 32'(vecs[i].dedge));
            chk($sformatf("v%0d_done_pulses", i), 32'(dones), 32'd1);
            chk($sformatf("v%0d_busy_cycles", i), 32'(busys), 32'(vecs[i].dedge));
            chk($sformatf("v%0d_first_addr", i), {16'd0, fa}, {16'd0, vecs[i].fa});
            chk($sformatf("v%0d_last_addr", i), {16'd0, la}, {16'd0, vecs[i].la});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
